// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and its decoder partner:
// opcode constants, the fetch FSM state encoding and default widths.
package fetch_sequencer_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 32;
   localparam int CNT_W_DEF   = 16;

   // Opcodes as seen by the decoder
   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_LOAD = 4'h1;
   localparam logic [3:0] OPC_STOR = 4'h2;
   localparam logic [3:0] OPC_MOVI = 4'h3;
   localparam logic [3:0] OPC_ADD  = 4'h4;
   localparam logic [3:0] OPC_SUB  = 4'h5;
   localparam logic [3:0] OPC_AND  = 4'h6;
   localparam logic [3:0] OPC_OR   = 4'h7;
   localparam logic [3:0] OPC_XOR  = 4'h8;
   localparam logic [3:0] OPC_SHL  = 4'h9;
   localparam logic [3:0] OPC_SHR  = 4'hA;
   localparam logic [3:0] OPC_BZ   = 4'hB;
   localparam logic [3:0] OPC_BN   = 4'hC;
   localparam logic [3:0] OPC_JMP  = 4'hD;
   localparam logic [3:0] OPC_JAL  = 4'hE;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_WAIT    = 2'd1,
      S_ISSUE   = 2'd2,
      S_RESOLVE = 2'd3
   } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, decoder-issue and branch-resolve signals of the
// fetch sequencer; master is the sequencer side.
interface fetch_sequencer_if
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) ();

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_valid;

   logic [INSTR_W-1:0] instr;
   logic [3:0]         opcode;
   logic               instr_valid;
   logic               instr_ready;

   logic               resolve_valid;
   logic               jump;
   logic               branchZ;
   logic               branchN;
   logic               flag_z;
   logic               flag_n;
   logic [PC_W-1:0]    target;

   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_link;
   logic [CNT_W-1:0]   retired;
   logic               err_spurious;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_valid,
      output instr, opcode, instr_valid,
      input  instr_ready,
      input  resolve_valid, jump, branchZ, branchN, flag_z, flag_n, target,
      output pc, pc_link, retired, err_spurious
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_valid,
      input  instr, opcode, instr_valid,
      output instr_ready,
      output resolve_valid, jump, branchZ, branchN, flag_z, flag_n, target,
      input  pc, pc_link, retired, err_spurious
   );

endinterface

// File: rtl/fetch_sequencer_next_pc_logic.sv
// Combinational next-PC resolution: jump overrides, either flagged branch
// condition redirects, otherwise fall through to pc+1 (wrapping).
module next_pc_logic
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] target,
   input  logic            jump,
   input  logic            branchZ,
   input  logic            branchN,
   input  logic            flag_z,
   input  logic            flag_n,
   output logic [PC_W-1:0] next_pc,
   output logic            taken,
   output logic [PC_W-1:0] pc_link
);

   assign pc_link = pc + PC_W'(1);
   assign taken   = jump | (branchZ & flag_z) | (branchN & flag_n);
   assign next_pc = taken ? target : pc_link;

endmodule

// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch sequencer: fetch, wait for memory, issue
// to the decoder, then resolve the next PC from branch/jump outcome.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int OPC_MSB = 31,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_sequencer_if.master  bus
);

   state_t             state, state_d;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    next_pc;
   logic [PC_W-1:0]    pc_link;
   logic               taken;
   logic [INSTR_W-1:0] instr_q;
   logic               instr_valid_q;
   logic [CNT_W-1:0]   retired_q;
   logic               err_q;

   logic               load_instr;
   logic               accept;
   logic               resolve;

   next_pc_logic #(.PC_W(PC_W)) u_next_pc (
      .pc      (pc_q),
      .target  (bus.target),
      .jump    (bus.jump),
      .branchZ (bus.branchZ),
      .branchN (bus.branchN),
      .flag_z  (bus.flag_z),
      .flag_n  (bus.flag_n),
      .next_pc (next_pc),
      .taken   (taken),
      .pc_link (pc_link)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_d;
   end

   // imem_valid/instr_ready/resolve_valid only matter in their own state
   always_comb begin
      state_d    = state;
      load_instr = 1'b0;
      accept     = 1'b0;
      resolve    = 1'b0;
      case (state)
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.imem_valid) begin
               load_instr = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.instr_ready) begin
               accept  = 1'b1;
               state_d = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            if (bus.resolve_valid) begin
               resolve = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         retired_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         if (load_instr) instr_q <= bus.imem_rdata;

         if (load_instr)  instr_valid_q <= 1'b1;
         else if (accept) instr_valid_q <= 1'b0;

         if (resolve) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + CNT_W'(1);
         end

         // A response with no outstanding request is a protocol error; sticky
         if (bus.imem_valid && (state != S_WAIT)) err_q <= 1'b1;
      end
   end

   // Gated by rst_n so no request is visible while reset is held
   assign bus.imem_req     = rst_n && (state == S_FETCH);
   assign bus.imem_addr    = pc_q;
   assign bus.instr        = instr_q;
   assign bus.opcode       = instr_q[OPC_MSB -: 4];
   assign bus.instr_valid  = instr_valid_q;
   assign bus.pc           = pc_q;
   assign bus.pc_link      = pc_link;
   assign bus.retired      = retired_q;
   assign bus.err_spurious = err_q;

   a_redirect_target: assert property (@(posedge clk) disable iff (!rst_n)
      taken |-> (next_pc == bus.target));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver issues random and directed
// instructions into a PC/retire model, a monitor checks fetches and issues.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_sequencer_if #(.PC_W(8), .INSTR_W(32), .CNT_W(16)) bus ();

   fetch_sequencer #(.PC_W(8), .INSTR_W(32), .OPC_MSB(31), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  pc;
      logic [15:0] retired;
   } issue_t;

   logic [7:0]  fetch_q[$];
   issue_t      issue_q[$];
   logic [31:0] mem [256];

   int n_checks = 0;
   int n_pass   = 0;
   bit exp_err;
   bit abort = 0;
   int mpc, mret;
   int lat_fix;

   logic        mem_valid  = 1'b0;
   logic        spur_valid = 1'b0;
   logic [31:0] mem_data   = '0;
   logic [31:0] junk       = '0;

   assign bus.imem_valid = mem_valid | spur_valid;
   assign bus.imem_rdata = mem_valid ? mem_data : junk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
   endtask

   // Instruction memory: one response per request after a 1..3 cycle latency
   initial begin
      bit         pend = 0;
      int         cnt  = 0;
      logic [7:0] a    = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.imem_req) begin
            pend = 1;
            a    = bus.imem_addr;
            cnt  = (lat_fix > 0) ? lat_fix : $urandom_range(1, 3);
         end
         @(posedge clk); #1;
         mem_valid = 1'b0;
         if (!rst_n) pend = 0;
         else if (pend) begin
            if (cnt <= 1) begin
               mem_valid = 1'b1;
               mem_data  = mem[a];
               pend      = 0;
            end else cnt--;
         end
      end
   end

   // Monitor: every fetch and every accepted issue is matched to the model
   initial begin
      logic [7:0] ea;
      issue_t     ei;
      logic [7:0] pl;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.imem_req) begin
               chk("req_expected", 64'(fetch_q.size() > 0), 64'd1);
               if (fetch_q.size() > 0) begin
                  ea = fetch_q.pop_front();
                  chk("imem_addr", 64'(bus.imem_addr), 64'(ea));
               end
            end
            if (bus.instr_valid && bus.instr_ready) begin
               chk("issue_expected", 64'(issue_q.size() > 0), 64'd1);
               if (issue_q.size() > 0) begin
                  ei = issue_q.pop_front();
                  pl = ei.pc + 8'd1;
                  chk("instr",        64'(bus.instr),        64'(ei.instr));
                  chk("opcode",       64'(bus.opcode),       64'(ei.instr >> 28));
                  chk("pc",           64'(bus.pc),           64'(ei.pc));
                  chk("pc_link",      64'(bus.pc_link),      64'(pl));
                  chk("retired",      64'(bus.retired),      64'(ei.retired));
                  chk("err_spurious", 64'(bus.err_spurious), 64'(exp_err));
               end
            end
         end
      end
   end

   task automatic push_expect();
      logic [7:0]  p = 8'(mpc);
      logic [15:0] r = 16'(mret);
      fetch_q.push_back(p);
      issue_q.push_back('{mem[mpc], p, r});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_err = 0;
      fetch_q.delete();
      issue_q.delete();
      bus.instr_ready   = 1'b0;
      bus.resolve_valid = 1'b0;
      repeat (3) begin
         spur_valid = ~spur_valid;
         junk = $urandom;
         @(negedge clk);
         chk("reset_outputs",
             64'({bus.imem_req, bus.instr_valid, bus.err_spurious, bus.pc, bus.retired, bus.instr}),
             64'd0);
         @(posedge clk); #1;
      end
      spur_valid = 1'b0;
      mpc = 0;
      mret = 0;
      push_expect();
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input bit jmp, input bit bz, input bit bn, input bit fz,
                            input bit fn, input logic [7:0] tgt, input int stall,
                            input bit inject);
      int          t = 0;
      int          gap;
      bit          tk;
      logic [31:0] e_instr = mem[mpc];
      if (abort) return;
      // Noise while fetching: stray ready and stray resolve must be ignored
      while (!bus.instr_valid && t < 200) begin
         bus.instr_ready   = 1'($urandom_range(0, 1));
         bus.resolve_valid = ($urandom_range(0, 3) == 0);
         bus.jump          = 1'b1;
         bus.target        = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
         t++;
      end
      bus.resolve_valid = 1'b0;
      bus.instr_ready   = 1'b0;
      if (!bus.instr_valid) begin
         chk("instr_valid_timeout", 64'(bus.instr_valid), 64'd1);
         abort = 1;
         return;
      end
      for (int s = 0; s < stall; s++) begin
         if (inject && s == 0) begin
            spur_valid = 1'b1;
            junk = $urandom;
         end
         @(posedge clk); #1;
         if (spur_valid) begin
            spur_valid = 1'b0;
            exp_err = 1;
            chk("err_spurious_set", 64'(bus.err_spurious), 64'd1);
         end
         chk("stall_hold", 64'({bus.instr_valid, bus.instr}), 64'({1'b1, e_instr}));
      end
      bus.instr_ready = 1'b1;
      @(posedge clk); #1;
      bus.instr_ready = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      bus.jump    = jmp;
      bus.branchZ = bz;
      bus.branchN = bn;
      bus.flag_z  = fz;
      bus.flag_n  = fn;
      bus.target  = tgt;
      bus.resolve_valid = 1'b1;
      tk   = jmp || (bz && fz) || (bn && fn);
      mpc  = tk ? int'(tgt) : (mpc + 1) % 256;
      mret = (mret + 1) % 65536;
      push_expect();
      @(posedge clk); #1;
      bus.resolve_valid = 1'b0;
   endtask

   task automatic rand_instr();
      int st = $urandom_range(0, 4);
      run_instr(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                st, (st > 0) && ($urandom_range(0, 5) == 0));
   endtask

   initial begin
      rst_n = 1'b0;
      bus.instr_ready = 1'b0; bus.resolve_valid = 1'b0;
      bus.jump = 1'b0; bus.branchZ = 1'b0; bus.branchN = 1'b0;
      bus.flag_z = 1'b0; bus.flag_n = 1'b0; bus.target = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h4000_0000;
      mem[1] = 32'h5000_0000;
      mem[2] = 32'h6000_0000;
      lat_fix = 2;
      @(posedge clk); #1;
      do_reset();

      run_instr(0, 0, 0, 0, 0, 8'h00, 0, 0);   // 0x00 -> 0x01
      run_instr(0, 0, 0, 0, 0, 8'h00, 0, 0);   // 0x01 -> 0x02
      run_instr(0, 0, 0, 0, 0, 8'h00, 0, 0);   // 0x02 -> 0x03
      run_instr(0, 1, 0, 1, 0, 8'h40, 0, 0);   // branchZ taken -> 0x40
      run_instr(0, 1, 0, 0, 0, 8'h99, 0, 0);   // branchZ not taken -> 0x41
      run_instr(0, 0, 1, 0, 1, 8'h10, 0, 0);   // branchN taken -> 0x10
      run_instr(1, 0, 0, 0, 0, 8'hFF, 0, 0);   // jump -> 0xFF
      run_instr(0, 0, 0, 0, 0, 8'h33, 0, 0);   // wrap 0xFF -> 0x00
      run_instr(1, 0, 0, 0, 0, 8'h80, 5, 0);   // backpressure, jump -> 0x80
      run_instr(0, 1, 1, 0, 1, 8'h22, 3, 1);   // both branches, spurious valid
      lat_fix = 0;
      repeat (40) rand_instr();

      // Reset while a fetch is outstanding
      lat_fix = 3;
      if (!abort) begin
         @(posedge clk); #1;
         do_reset();
      end
      lat_fix = 0;
      repeat (6) rand_instr();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=finished", n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side partner of the opcode-to-control decoder.
- Fetches one instruction at a time from instruction memory and presents the instruction and its 4-bit opcode to the decoder.
- Consumes the decoder's branch/jump outputs plus ALU flags to resolve the next PC.
- Non-pipelined: exactly one instruction in flight, matching the single-issue datapath.

Parameters:
PC_W, 8, program counter / imem address width
INSTR_W, 32, instruction width
OPC_MSB, 31, bit index of opcode MSB; opcode = instr[OPC_MSB -: 4]
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request, one-cycle pulse
imem_addr  out  PC_W  read address (= pc)
imem_rdata  in  INSTR_W  read data
imem_valid  in  1  read data valid, one-cycle pulse
instr  out  INSTR_W  registered instruction to decode
opcode  out  4  instr[OPC_MSB -: 4], to decoder
instr_valid  out  1  instr/opcode valid
instr_ready  in  1  downstream accepts instr
resolve_valid  in  1  branch inputs below are valid for the current instruction
jump  in  1  unconditional redirect
branchZ  in  1  branch if flag_z
branchN  in  1  branch if flag_n
flag_z  in  1  ALU zero flag
flag_n  in  1  ALU negative flag
target  in  PC_W  redirect target (register or memory sourced)
pc  out  PC_W  current PC
pc_link  out  PC_W  pc+1, for PCtoReg writeback
retired  out  CNT_W  resolved-instruction count
err_spurious  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=S_FETCH, pc=0, instr=0, instr_valid=0, imem_req=0, retired=0, err_spurious=0.
- Reset asserted mid-operation aborts any in-flight fetch or resolution immediately. The memory shares rst_n, so no stale response survives reset.

States:
- S_FETCH:
  - imem_req=1, imem_addr=pc for exactly one cycle.
  - Next state: S_WAIT.
- S_WAIT:
  - Waits for imem_valid, with unbounded latency (minimum 1 cycle after the req cycle).
  - On imem_valid: instr<=imem_rdata, instr_valid<=1, next state S_ISSUE.
- S_ISSUE:
  - instr_valid=1; instr and opcode held stable.
  - On instr_ready=1: instr_valid<=0, next state S_RESOLVE.
  - Holding instr_ready low stalls indefinitely, with no new imem_req.
- S_RESOLVE:
  - Waits for resolve_valid. This covers the decoder's registered one-cycle output latency plus the ALU.
  - On resolve_valid: taken = jump | (branchZ & flag_z) | (branchN & flag_n).
  - pc <= taken ? target : pc+1.
  - retired <= retired+1.
  - Next state: S_FETCH.

Arithmetic and boundaries:
- pc+1 and retired wrap modulo 2^PC_W and 2^CNT_W. No saturation.
- pc_link = pc+1 (wrapping), combinational from the pc register.
- branchZ and branchN both set: either flag true takes the branch. jump overrides the flags.
- imem_valid in any state other than S_WAIT: ignored (instr unchanged) and err_spurious<=1. err_spurious clears only on reset.
- resolve_valid outside S_RESOLVE: ignored, no flag.
- imem_valid and instr_ready asserted together in S_WAIT: instr_ready is ignored; the transfer completes in S_ISSUE on a later cycle.
- Minimum loop per instruction: FETCH, WAIT (1), ISSUE (1), RESOLVE (1) = 4 cycles.

Decomposition:
- Shared package/include cpu_defs: 4-bit opcode constants used by the decoder, state encodings S_FETCH/S_WAIT/S_ISSUE/S_RESOLVE (2-bit), and default PC_W/INSTR_W.
- One sub-module, next_pc_logic: purely combinational.
  - Inputs: pc, target, jump, branchZ, branchN, flag_z, flag_n.
  - Outputs: next_pc, taken, pc_link.
  - Verified standalone.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with imem_valid toggling → all outputs at reset values, imem_req=0. First cycle after release: imem_req=1, imem_addr=0x00.
- Sequential: memory latency 2, returns 0x40000000, 0x50000000, 0x60000000, each resolved untaken → imem_addr 0x00, 0x01, 0x02; opcode 4, 5, 6; retired=3.
- Branch: branchZ=1, target=0x40, flag_z=1 → next imem_addr=0x40. Repeat with flag_z=0 → 0x41. branchN=1, flag_n=1, target=0x10 → 0x10.
- Wrap/jump: pc=0xFF untaken → next 0x00, pc_link was 0x00. jump=1, target=0x80 with flags 0 → 0x80.
- Backpressure: instr_ready=0 for 5 cycles in S_ISSUE → instr_valid=1 and instr stable throughout, no imem_req. Ready on cycle 6 → S_RESOLVE.
- Errors/reset: imem_valid pulsed in S_ISSUE → err_spurious=1, instr unchanged. rst_n dropped while in S_WAIT → pc=0, err_spurious=0, fetch restarts at 0x00.
